// File: rtl/sensor_emu_pkg.sv
// Shared sensor_emu definitions: scheduler FSM encoding, frame timing limits
// and the generator's header/footer cycle counts.
package sensor_emu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_REQ    = 3'd2,
    ST_WAIT   = 3'd3,
    ST_FINISH = 3'd4
  } sched_state_t;

  localparam int unsigned MIN_FRAME_PERIOD = 256;
  localparam int unsigned GEN_HDR_CYCLES   = 4;
  localparam int unsigned GEN_FTR_CYCLES   = 2;

  // Short periods would not leave room for a generator frame, so clamp them.
  function automatic logic [31:0] eff_period(input logic [31:0] period);
    return (period < 32'(MIN_FRAME_PERIOD)) ? 32'(MIN_FRAME_PERIOD) : period;
  endfunction

endpackage

// File: rtl/sensor_emu_period_timer.sv
// Frame period counter: cleared on load, wraps to 0 after 'last', and flags
// the terminal count combinationally while running.
module sensor_emu_period_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        run,
  input  logic [31:0] last,
  output logic        tc
);

  logic [31:0] cnt;

  assign tc = run && (cnt == last);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (load || tc) begin
      cnt <= '0;
    end else if (run) begin
      cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: rtl/sensor_emu_sched.sv
// Frame scheduler for sensor_emu_gen: paces rs0/rs256 triggers, sources the
// per-frame pattern on an AXI-stream master, counts frames and overruns.
module sensor_emu_sched
  import sensor_emu_pkg::*;
#(
  parameter int PATTERN_WIDTH = 32,
  parameter int OVR_WIDTH     = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     stop,
  input  logic [31:0]              frame_count,
  input  logic [31:0]              frame_period,
  input  logic [PATTERN_WIDTH-1:0] pattern_seed,
  input  logic [PATTERN_WIDTH-1:0] pattern_step,
  output logic                     rs0,
  output logic                     rs256,
  output logic [PATTERN_WIDTH-1:0] PATTERN_TDATA,
  output logic                     PATTERN_TVALID,
  input  logic                     PATTERN_TREADY,
  output logic                     busy,
  output logic                     done,
  output logic [31:0]              frames_sent,
  output logic [OVR_WIDTH-1:0]     overruns
);

  sched_state_t state, state_nxt;

  logic [31:0]              cfg_count;
  logic [31:0]              cfg_last;
  logic [PATTERN_WIDTH-1:0] cfg_step;
  logic                     odd;
  logic                     stop_pend;
  logic                     tc;
  logic                     start_acc;
  logic                     hs;
  logic                     last_frame;

  assign start_acc  = (state == ST_IDLE) && start;
  assign hs         = (state == ST_REQ) && PATTERN_TVALID && PATTERN_TREADY;
  assign last_frame = (cfg_count != 32'd0) && ((frames_sent + 32'd1) == cfg_count);

  // Counter restarts on start so it reads 0 during the first LOAD cycle;
  // afterwards every LOAD coincides with a terminal-count wrap.
  sensor_emu_period_timer u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (start_acc),
    .run   (state != ST_IDLE),
    .last  (cfg_last),
    .tc    (tc)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_LOAD;
      ST_LOAD:   state_nxt = stop ? ST_FINISH : ST_REQ;
      ST_REQ:    if (hs) state_nxt = (last_frame || stop_pend || stop) ? ST_FINISH : ST_WAIT;
      ST_WAIT: begin
        if (stop || stop_pend) state_nxt = ST_FINISH;
        else if (tc)           state_nxt = ST_LOAD;
      end
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rs0            <= 1'b0;
      rs256          <= 1'b0;
      PATTERN_TDATA  <= '0;
      PATTERN_TVALID <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      frames_sent    <= '0;
      overruns       <= '0;
      cfg_count      <= '0;
      cfg_last       <= '0;
      cfg_step       <= '0;
      odd            <= 1'b0;
      stop_pend      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (stop) stop_pend <= 1'b1;
      case (state)
        ST_IDLE: begin
          stop_pend <= 1'b0;
          if (start) begin
            busy          <= 1'b1;
            frames_sent   <= '0;
            overruns      <= '0;
            PATTERN_TDATA <= pattern_seed;
            cfg_count     <= frame_count;
            cfg_last      <= eff_period(frame_period) - 32'd1;
            cfg_step      <= pattern_step;
            odd           <= 1'b0;
            stop_pend     <= stop;
          end
        end
        ST_LOAD: begin
          if (!stop) begin
            PATTERN_TVALID <= 1'b1;
            rs0            <= !odd;
            rs256          <= odd;
          end
        end
        ST_REQ: begin
          if (hs) begin
            rs0            <= 1'b0;
            rs256          <= 1'b0;
            PATTERN_TVALID <= 1'b0;
            frames_sent    <= frames_sent + 32'd1;
            PATTERN_TDATA  <= PATTERN_TDATA + cfg_step;
            odd            <= !odd;
          end else if (tc && (overruns != {OVR_WIDTH{1'b1}})) begin
            overruns <= overruns + 1'b1;
          end
        end
        ST_FINISH: begin
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sensor_emu_sched.sv
// Directed bench for sensor_emu_sched: a TREADY responder with programmable
// delay, a trigger/done monitor, and one task per scenario.
module tb_sensor_emu_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        stop;
  logic [31:0] frame_count;
  logic [31:0] frame_period;
  logic [31:0] pattern_seed;
  logic [31:0] pattern_step;
  logic        rs0;
  logic        rs256;
  logic [31:0] PATTERN_TDATA;
  logic        PATTERN_TVALID;
  logic        PATTERN_TREADY;
  logic        busy;
  logic        done;
  logic [31:0] frames_sent;
  logic [15:0] overruns;

  sensor_emu_sched #(.PATTERN_WIDTH(32), .OVR_WIDTH(16)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .stop           (stop),
    .frame_count    (frame_count),
    .frame_period   (frame_period),
    .pattern_seed   (pattern_seed),
    .pattern_step   (pattern_step),
    .rs0            (rs0),
    .rs256          (rs256),
    .PATTERN_TDATA  (PATTERN_TDATA),
    .PATTERN_TVALID (PATTERN_TVALID),
    .PATTERN_TREADY (PATTERN_TREADY),
    .busy           (busy),
    .done           (done),
    .frames_sent    (frames_sent),
    .overruns       (overruns)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // TREADY rises once TVALID has been seen high for rdy_delay falling edges.
  int rdy_delay = 2;
  int vld_age   = 0;
  initial PATTERN_TREADY = 1'b0;
  always @(negedge clk) begin
    if (PATTERN_TVALID) begin
      vld_age = vld_age + 1;
      PATTERN_TREADY = (vld_age >= rdy_delay);
    end else begin
      vld_age = 0;
      PATTERN_TREADY = 1'b0;
    end
  end

  // Trigger monitor: rising edges of rs0/rs256 with cycle stamp and pattern.
  logic        p0 = 1'b0;
  logic        p1 = 1'b0;
  int          trig_cyc[$];
  int          trig_kind[$];
  logic [31:0] trig_dat[$];
  int          done_cnt = 0;
  int          rs_hi    = 0;
  int          overlap  = 0;
  always @(negedge clk) begin
    if (rs0 && !p0) begin
      trig_cyc.push_back(cyc); trig_kind.push_back(0); trig_dat.push_back(PATTERN_TDATA);
    end
    if (rs256 && !p1) begin
      trig_cyc.push_back(cyc); trig_kind.push_back(1); trig_dat.push_back(PATTERN_TDATA);
    end
    if (rs0 || rs256) rs_hi = rs_hi + 1;
    if (rs0 && rs256) overlap = overlap + 1;
    if (done) done_cnt = done_cnt + 1;
    p0 = rs0;
    p1 = rs256;
  end

  bit ok;
  int c0;

  task clear_mon();
    @(posedge clk);
    trig_cyc.delete(); trig_kind.delete(); trig_dat.delete();
    done_cnt = 0;
    rs_hi    = 0;
  endtask

  task pulse_start(input bit with_stop);
    @(negedge clk);
    start = 1'b1; stop = with_stop;
    @(negedge clk);
    start = 1'b0; stop = 1'b0;
  endtask

  task wait_done(input int budget, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  task test_reset();
    reset = 1'b1; start = 1'b0; stop = 1'b0;
    frame_count = 0; frame_period = 0; pattern_seed = 0; pattern_step = 0;
    repeat (3) @(negedge clk);
    checks++; if ({rs0, rs256, PATTERN_TVALID, busy, done} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000", {rs0, rs256, PATTERN_TVALID, busy, done});
    end
    checks++; if (PATTERN_TDATA !== 32'h0) begin
      errors++; $display("FAIL reset_tdata: got %h expected 0", PATTERN_TDATA);
    end
    checks++; if (frames_sent !== 32'd0 || overruns !== 16'd0) begin
      errors++; $display("FAIL reset_counters: got %0d/%0d expected 0/0", frames_sent, overruns);
    end
    reset = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task test_basic();
    frame_count = 3; frame_period = 300; pattern_seed = 32'h11223344; pattern_step = 1;
    rdy_delay = 2;
    clear_mon();
    pulse_start(1'b0);
    frame_count = 0; frame_period = 1000; pattern_seed = 0; pattern_step = 5;
    wait_done(2000, ok);
    repeat (3) @(negedge clk);
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL basic_done_timeout: got %0d expected 1", ok);
    end
    checks++; if (trig_cyc.size() !== 3) begin
      errors++; $display("FAIL basic_trig_count: got %0d expected 3", trig_cyc.size());
    end
    if (trig_cyc.size() == 3) begin
      checks++; if ({trig_kind[0][0], trig_kind[1][0], trig_kind[2][0]} !== 3'b010) begin
        errors++; $display("FAIL basic_trig_order: got %0d%0d%0d expected 010", trig_kind[0], trig_kind[1], trig_kind[2]);
      end
      checks++; if (trig_cyc[1] - trig_cyc[0] !== 300 || trig_cyc[2] - trig_cyc[1] !== 300) begin
        errors++; $display("FAIL basic_spacing: got %0d,%0d expected 300,300", trig_cyc[1] - trig_cyc[0], trig_cyc[2] - trig_cyc[1]);
      end
      checks++; if (trig_dat[0] !== 32'h11223344 || trig_dat[1] !== 32'h11223345 || trig_dat[2] !== 32'h11223346) begin
        errors++; $display("FAIL basic_tdata: got %h %h %h expected 11223344 11223345 11223346", trig_dat[0], trig_dat[1], trig_dat[2]);
      end
    end
    checks++; if (done_cnt !== 1) begin
      errors++; $display("FAIL basic_done_pulses: got %0d expected 1", done_cnt);
    end
    checks++; if (frames_sent !== 32'd3 || overruns !== 16'd0) begin
      errors++; $display("FAIL basic_counters: got %0d/%0d expected 3/0", frames_sent, overruns);
    end
    checks++; if (busy !== 1'b0 || PATTERN_TDATA !== 32'h11223347) begin
      errors++; $display("FAIL basic_final: got busy=%b tdata=%h expected busy=0 tdata=11223347", busy, PATTERN_TDATA);
    end
    checks++; if (rs_hi !== 6) begin
      errors++; $display("FAIL basic_rs_high_cycles: got %0d expected 6", rs_hi);
    end
  endtask

  task test_min_period();
    frame_count = 2; frame_period = 100; pattern_seed = 7; pattern_step = 2;
    rdy_delay = 2;
    clear_mon();
    pulse_start(1'b0);
    wait_done(1500, ok);
    repeat (2) @(negedge clk);
    checks++; if (ok !== 1'b1 || trig_cyc.size() !== 2) begin
      errors++; $display("FAIL minper_run: got done=%0d trigs=%0d expected 1/2", ok, trig_cyc.size());
    end
    if (trig_cyc.size() == 2) begin
      checks++; if (trig_cyc[1] - trig_cyc[0] !== 256) begin
        errors++; $display("FAIL minper_spacing: got %0d expected 256", trig_cyc[1] - trig_cyc[0]);
      end
      checks++; if (trig_kind[0] !== 0 || trig_kind[1] !== 1 || trig_dat[1] !== 32'd9) begin
        errors++; $display("FAIL minper_trig: got kinds %0d,%0d data %0d expected 0,1 data 9", trig_kind[0], trig_kind[1], trig_dat[1]);
      end
    end
  endtask

  task test_overrun();
    frame_count = 1; frame_period = 256; pattern_seed = 32'h55; pattern_step = 1;
    rdy_delay = 700;
    clear_mon();
    pulse_start(1'b0);
    wait_done(3000, ok);
    repeat (2) @(negedge clk);
    rdy_delay = 2;
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL ovr_done_timeout: got %0d expected 1", ok);
    end
    checks++; if (overruns !== 16'd2) begin
      errors++; $display("FAIL ovr_count: got %0d expected 2", overruns);
    end
    checks++; if (trig_cyc.size() !== 1 || frames_sent !== 32'd1) begin
      errors++; $display("FAIL ovr_single_frame: got trigs=%0d frames=%0d expected 1/1", trig_cyc.size(), frames_sent);
    end
    checks++; if (rs_hi !== 700) begin
      errors++; $display("FAIL ovr_rs0_held: got %0d expected 700", rs_hi);
    end
  endtask

  task test_stop_in_wait();
    frame_count = 0; frame_period = 256; pattern_seed = 0; pattern_step = 1;
    rdy_delay = 2;
    clear_mon();
    pulse_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (frames_sent == 32'd5) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL stop_reach5_timeout: got frames=%0d expected 5", frames_sent);
    end
    stop = 1'b1;
    c0 = cyc;
    @(negedge clk);
    stop = 1'b0;
    wait_done(10, ok);
    checks++; if (ok !== 1'b1 || cyc - c0 !== 2) begin
      errors++; $display("FAIL stop_finish_latency: got done=%0d after %0d cycles expected 1 after 2", ok, cyc - c0);
    end
    repeat (600) @(negedge clk);
    checks++; if (trig_cyc.size() !== 5 || frames_sent !== 32'd5) begin
      errors++; $display("FAIL stop_frames: got trigs=%0d frames=%0d expected 5/5", trig_cyc.size(), frames_sent);
    end
    checks++; if (done_cnt !== 1 || busy !== 1'b0) begin
      errors++; $display("FAIL stop_done: got pulses=%0d busy=%b expected 1/0", done_cnt, busy);
    end
  endtask

  task test_start_stop();
    frame_count = 0; frame_period = 256; pattern_seed = 32'hCAFE; pattern_step = 1;
    rdy_delay = 2;
    clear_mon();
    pulse_start(1'b1);
    wait_done(600, ok);
    repeat (300) @(negedge clk);
    checks++; if (ok !== 1'b1 || done_cnt !== 1) begin
      errors++; $display("FAIL ss_done: got seen=%0d pulses=%0d expected 1/1", ok, done_cnt);
    end
    checks++; if (trig_cyc.size() !== 1 || frames_sent !== 32'd1) begin
      errors++; $display("FAIL ss_one_frame: got trigs=%0d frames=%0d expected 1/1", trig_cyc.size(), frames_sent);
    end
    if (trig_cyc.size() == 1) begin
      checks++; if (trig_kind[0] !== 0 || trig_dat[0] !== 32'hCAFE) begin
        errors++; $display("FAIL ss_trig: got kind=%0d data=%h expected 0/0000cafe", trig_kind[0], trig_dat[0]);
      end
    end
  endtask

  task test_reset_midrun();
    frame_count = 0; frame_period = 256; pattern_seed = 32'hA0; pattern_step = 32'h10;
    rdy_delay = 2;
    clear_mon();
    pulse_start(1'b0);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (rs256) begin
        ok = 1'b1;
        break;
      end
    end
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL rst_rs256_timeout: got %0d expected 1", ok);
    end
    #2 reset = 1'b1;
    #1;
    checks++; if ({rs0, rs256, PATTERN_TVALID, busy} !== 4'b0) begin
      errors++; $display("FAIL rst_async_drop: got %b expected 0000", {rs0, rs256, PATTERN_TVALID, busy});
    end
    checks++; if (frames_sent !== 32'd0 || PATTERN_TDATA !== 32'd0) begin
      errors++; $display("FAIL rst_async_regs: got frames=%0d tdata=%h expected 0/0", frames_sent, PATTERN_TDATA);
    end
    @(negedge clk);
    reset = 1'b0;
    clear_mon();
    pulse_start(1'b0);
    repeat (5) @(negedge clk);
    checks++; if (trig_cyc.size() !== 1) begin
      errors++; $display("FAIL rst_restart_trig: got %0d expected 1", trig_cyc.size());
    end
    if (trig_cyc.size() == 1) begin
      checks++; if (trig_kind[0] !== 0 || trig_dat[0] !== 32'hA0) begin
        errors++; $display("FAIL rst_restart_seed: got kind=%0d data=%h expected 0/000000a0", trig_kind[0], trig_dat[0]);
      end
    end
    @(negedge clk);
    stop = 1'b1;
    @(negedge clk);
    stop = 1'b0;
    wait_done(600, ok);
    checks++; if (ok !== 1'b1) begin
      errors++; $display("FAIL rst_stop_done: got %0d expected 1", ok);
    end
  endtask

  task test_exclusive();
    checks++; if (overlap !== 0) begin
      errors++; $display("FAIL rs_exclusive: got %0d overlap cycles expected 0", overlap);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_min_period();
    test_overrun();
    test_stop_in_wait();
    test_start_stop();
    test_reset_midrun();
    test_exclusive();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
